// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage; one radix-2 step per falling clock edge.
// Define MULDIV_FAST_MUL_EN to compute all multiplies in one edge with a combinational multiplier.
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              qneg_q, qneg_d, rneg_q, rneg_d;
  logic [XLEN-1:0]   result_q, result_d;

  // operand decode on the incoming instruction
  logic            a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag, spec_res;

  always_comb begin
    a_sgn    = op[2] ? ~op[0] : (op == 3'b001 || op == 3'b010);
    b_sgn    = op[2] ? ~op[0] : (op == 3'b001);
    a_neg    = a_sgn & a[XLEN-1];
    b_neg    = b_sgn & b[XLEN-1];
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
    div_zero = op[2] && (b == '0);
    div_ovf  = op[2] && !op[0] && (a == SMIN) && (b == '1);
    if (div_zero) spec_res = op[1] ? a : '1;
    else          spec_res = op[1] ? '0 : SMIN;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fa, fb, fprod;
  logic [XLEN-1:0]   fast_res;
  always_comb begin
    fa       = {{XLEN{a_sgn & a[XLEN-1]}}, a};
    fb       = {{XLEN{b_sgn & b[XLEN-1]}}, b};
    fprod    = fa * fb;
    fast_res = (op[1:0] == 2'b00) ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
  end
`endif

  // one iteration: acc holds {partial product, multiplier} or {remainder, quotient}
  logic [XLEN:0]     msum, dtrial;
  logic [2*XLEN-1:0] acc_step, prod;
  logic [XLEN-1:0]   quo, rem, fin;

  always_comb begin
    msum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
    dtrial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, dvs_q};
    if (op_q[2])
      acc_step = dtrial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                              : {dtrial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    else
      acc_step = {msum, acc_q[XLEN-1:1]};
    prod = qneg_q ? -acc_step : acc_step;
    quo  = qneg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    rem  = rneg_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
    if (op_q[2])              fin = op_q[1] ? rem : quo;
    else if (op_q[1:0] == '0) fin = prod[XLEN-1:0];
    else                      fin = prod[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    dvs_d    = dvs_q;
    acc_d    = acc_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          op_d   = op;
          dvs_d  = b_mag;
          acc_d  = {{XLEN{1'b0}}, a_mag};
          qneg_d = a_neg ^ b_neg;
          rneg_d = a_neg;
          cnt_d  = '0;
          if (div_zero || div_ovf) begin
            result_d = spec_res;
            state_d  = DONE;
          end
`ifdef MULDIV_FAST_MUL_EN
          else if (!op[2]) begin
            result_d = fast_res;
            state_d  = DONE;
          end
`endif
          else state_d = CALC;
        end
        CALC: begin
          acc_d = acc_step;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(XLEN-1)) begin
            result_d = fin;
            state_d  = DONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      dvs_q    <= '0;
      acc_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      dvs_q    <= dvs_d;
      acc_q    <= acc_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

  assign stall  = (state_q == IDLE && start && !flush) || (state_q == CALC);
  assign busy   = (state_q == CALC);
  assign done   = (state_q == DONE);
  assign result = result_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit; inputs change and outputs are sampled around the rising edge.
module tb_ex_muldiv_unit;
  localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  logic            clk = 1'b0, rst = 1'b0, start = 1'b0, flush = 1'b0;
  logic [2:0]      op = '0;
  logic [XLEN-1:0] a = '0, b = '0;
  logic            stall, busy, done;
  logic [XLEN-1:0] result;
  int checks = 0, passed = 0, fails = 0;
  int n, dc;

  ex_muldiv_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .stall(stall), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", nm, got, exp);
    end
  endtask

  // issue one instruction, drop start after the sampling edge, and check latency/stall/result/pulse
  task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] e, input int lat);
    int cyc, sc;
    @(posedge clk); start = 1'b1; op = o; a = x; b = y; #1;
    cyc = 0; sc = 0;
    while (done !== 1'b1 && cyc < 100) begin
      if (stall) sc++;
      @(posedge clk); start = 1'b0; #1;
      cyc++;
    end
    chk({nm, " latency"}, cyc, lat);
    chk({nm, " stall cycles"}, sc, lat);
    chk({nm, " result"}, result, e);
    @(posedge clk); #1;
    chk({nm, " single pulse"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    #12;
    chk("reset done", {31'b0, done}, 0);
    chk("reset busy", {31'b0, busy}, 0);
    chk("reset stall", {31'b0, stall}, 0);
    chk("reset result", result, 0);
    @(posedge clk); rst = 1'b1;

    run_op("MUL 7*-3",      3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT);
    run_op("MULH 7*-3",     3'b001, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, MUL_LAT);
    run_op("MULHU 7*-3",    3'b011, 32'd7, 32'hFFFFFFFD, 32'h00000006, MUL_LAT);
    run_op("MULHSU -1*2",   3'b010, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, MUL_LAT);
    run_op("DIV -7/2",      3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    run_op("REM -7/2",      3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
    run_op("DIV 7/-2",      3'b100, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 33);
    run_op("REM 7/-2",      3'b110, 32'd7, 32'hFFFFFFFE, 32'd1, 33);
    run_op("DIVU 100/7",    3'b101, 32'd100, 32'd7, 32'd14, 33);
    run_op("REMU 100/7",    3'b111, 32'd100, 32'd7, 32'd2, 33);
    run_op("DIV 5/0",       3'b100, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
    run_op("REMU 5/0",      3'b111, 32'd5, 32'd0, 32'd5, 1);
    run_op("DIV ovf",       3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("REM ovf",       3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);

    // flush beats start in IDLE
    @(posedge clk); start = 1'b1; flush = 1'b1; op = 3'b100; a = 32'd5; b = 32'd0; #1;
    chk("flush prio stall", {31'b0, stall}, 0);
    @(posedge clk); start = 1'b0; flush = 1'b0; #1;
    chk("flush prio done", {31'b0, done}, 0);
    chk("flush prio busy", {31'b0, busy}, 0);

    // flush mid-divide
    @(posedge clk); start = 1'b1; op = 3'b101; a = 32'd1000; b = 32'd3;
    @(posedge clk); start = 1'b0; #1;
    chk("flush busy before", {31'b0, busy}, 1);
    repeat (10) @(posedge clk);
    flush = 1'b1;
    @(posedge clk); flush = 1'b0; #1;
    chk("flush busy", {31'b0, busy}, 0);
    chk("flush stall", {31'b0, stall}, 0);
    chk("flush result held", result, 32'd0);
    dc = 0;
    repeat (40) begin @(posedge clk); #1; if (done) dc++; end
    chk("flush no done", dc, 0);
    run_op("DIVU after flush", 3'b101, 32'd1000, 32'd3, 32'd333, 33);

    // back-to-back with start held high through DONE
    @(posedge clk); start = 1'b1; op = 3'b000; a = 32'd7; b = 32'hFFFFFFFD; #1;
    n = 0;
    while (done !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    chk("b2b first latency", n, MUL_LAT);
    chk("b2b first result", result, 32'hFFFFFFEB);
    op = 3'b011;
    @(posedge clk); #1;
    chk("b2b no retrigger done", {31'b0, done}, 0);
    chk("b2b no retrigger busy", {31'b0, busy}, 0);
    chk("b2b idle stall", {31'b0, stall}, 1);
    n = 0;
    while (done !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    start = 1'b0;
    chk("b2b second latency", n, MUL_LAT);
    chk("b2b second result", result, 32'd6);
    dc = 0;
    repeat (3) begin @(posedge clk); #1; if (done || busy) dc++; end
    chk("b2b quiet after", dc, 0);

    // asynchronous reset mid-CALC
    @(posedge clk); start = 1'b1; op = 3'b101; a = 32'd100; b = 32'd7;
    @(posedge clk); start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("pre-reset busy", {31'b0, busy}, 1);
    rst = 1'b0; #1;
    chk("async rst done", {31'b0, done}, 0);
    chk("async rst busy", {31'b0, busy}, 0);
    chk("async rst result", result, 0);
    chk("async rst stall", {31'b0, stall}, 0);
    @(posedge clk); rst = 1'b1;
    run_op("MUL 3*4", 3'b000, 32'd3, 32'd4, 32'd12, MUL_LAT);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage of the pipelined CPU.
- Consumes operands from the ID/EX pipeline register and feeds its result to the EX/MEM pipeline register.
- Drives a stall request that the hazard logic uses to hold write_enable low on the upstream pipeline registers until the result is ready.

Parameters:
- XLEN, 32, operand/result width; counter sized ceil(log2(XLEN))+1.

Ports:
- clk  input  1  clock; all state updates on the falling edge, matching the pipeline registers.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  ID/EX holds a valid M-extension instruction.
- op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  input  XLEN  rs1 value.
- b  input  XLEN  rs2 value.
- flush  input  1  pipeline flush; aborts the current operation.
- stall  output  1  hold request to the hazard unit.
- busy  output  1  state is CALC.
- done  output  1  one-cycle pulse; result valid.
- result  output  XLEN  registered result.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, counter=0, done=0, result=0, internal accumulators=0.
  - Reset mid-operation discards all work.
- States: IDLE, CALC, DONE.
- IDLE:
  - Falling edge with start=1 and flush=0: latch op, a, b.
  - Special case (div/rem with b=0, or DIV/REM with a=0x80000000 and b=0xFFFFFFFF): go to DONE with result loaded immediately.
  - Otherwise: go to CALC with counter=0.
- CALC:
  - One radix-2 iteration per falling edge, counter+1.
  - Multiply: shift-add on unsigned magnitudes into a 2*XLEN accumulator.
  - Divide: restoring shift-subtract on unsigned magnitudes.
  - The edge performing iteration XLEN (counter reaches XLEN) applies the sign fix, loads result, and enters DONE.
- DONE:
  - done=1 for exactly this cycle.
  - Next falling edge returns to IDLE unconditionally.
  - start is ignored in DONE and CALC.
- Latency:
  - Normal op: done high in the cycle after the XLEN-th edge following the start-sampling edge (32 edges for XLEN=32).
  - Special case: done high in the cycle after the sampling edge.
- stall = (state==IDLE & start & ~flush) | (state==CALC). stall is 0 in DONE, so EX/MEM captures result and ID/EX advances on the same edge the unit returns to IDLE.
- Signedness:
  - MULH and DIV/REM treat both operands as signed.
  - MULHSU treats a as signed, b as unsigned.
  - MULHU, DIVU, REMU treat both as unsigned. MUL uses the low half, so signedness is irrelevant.
  - Product is negated (64-bit two's complement) if operand signs differ.
  - Quotient is negated if signs differ; remainder takes the dividend's sign.
- Result selection:
  - MUL returns product[XLEN-1:0]; MULH/MULHSU/MULHU return product[2*XLEN-1:XLEN].
- Special results:
  - Divide by zero: DIV and DIVU return 0xFFFFFFFF; REM and REMU return a.
  - Overflow (0x80000000 / -1): DIV returns 0x80000000; REM returns 0.
- flush:
  - Synchronous abort: any state goes to IDLE, counter=0, done=0, result holds its old value.
  - flush has priority over start on the same edge.
- result holds its last value in IDLE until the next load.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined: MUL/MULH/MULHSU/MULHU are computed in one edge by a combinational 2*XLEN signed multiply. IDLE goes directly to DONE; done is high in the cycle after the sampling edge, same timing as the divide special cases. Divides remain iterative.
- Undefined: all multiplies are iterative with XLEN-cycle latency as specified above.

Test Plan:
- MUL a=7, b=-3 (0xFFFFFFFD) -> stall high 33 cycles, done pulse once, result=0xFFFFFFEB; MULH same operands -> 0xFFFFFFFF; MULHU -> 0x00000006.
- DIV a=-7, b=2 -> result=0xFFFFFFFD (-3); REM -> 0xFFFFFFFF (-1); DIVU a=100, b=7 -> 14; REMU -> 2.
- DIV a=5, b=0 -> done one cycle after start with 0xFFFFFFFF; REMU a=5, b=0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0.
- start a DIVU, assert flush at iteration 10 -> state IDLE next edge, stall=0, done never pulses, result unchanged; a new start then completes correctly.
- Hold start high through DONE (back-to-back MULs with stall releasing) -> exactly one operation per instruction, no re-trigger in DONE; the second start is accepted only from IDLE.
- Pull rst low mid-CALC -> done=0, result=0, busy=0 immediately (asynchronous); release, run MUL 3*4 -> 12.
